// File: rtl/aes_spi_pkg.sv
// Shared constants and types for the AES SPI slave front-end.
//   - command byte values
//   - frame length constants (write length depends on key width)
//   - FSM state encoding
package aes_spi_pkg;

  localparam logic [7:0] CMD_ENC = 8'h01;
  localparam logic [7:0] CMD_DEC = 8'h02;
  localparam logic [7:0] CMD_RD  = 8'h03;

  localparam int BLK_W   = 128;
  localparam int RD_BITS = 8 + BLK_W;
  // Wide enough for the longest write frame (8+128+256 = 392 bits).
  localparam int CNT_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    READY = 2'd3
  } state_e;

  // Write frame length: command + block + key.
  function automatic int wr_bits(input int key_w);
    return 8 + BLK_W + key_w;
  endfunction

endpackage

// File: rtl/aes_spi_slave_if.sv
// Bundle of the SPI pins, the AES core handshake and the status flags.
//   slave  : seen from the SPI front-end (drives miso, core controls, status)
//   master : seen from the environment (SPI master + AES core)
interface aes_spi_slave_if #(
  parameter int KEY_W = 128
);
  logic             spi_sclk;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;
  logic             aes_start;
  logic             aes_encrypt;
  logic [127:0]     aes_data;
  logic [KEY_W-1:0] aes_key;
  logic             aes_done;
  logic [127:0]     aes_result;
  logic             busy;
  logic             result_valid;
  logic             frame_err;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, aes_done, aes_result,
    output spi_miso, aes_start, aes_encrypt, aes_data, aes_key,
           busy, result_valid, frame_err
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, aes_done, aes_result,
    input  spi_miso, aes_start, aes_encrypt, aes_data, aes_key,
           busy, result_valid, frame_err
  );

endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus edge pulse generation.
//   in : clk, rst, spi_sclk, spi_cs_n, spi_mosi (asynchronous pins)
//   out: sclk_rise/sclk_fall, cs_fall/cs_rise (one-cycle pulses),
//        cs_n_s, mosi_s (synchronised levels, aligned with the pulses)
module spi_pin_sync (
  input  logic clk,
  input  logic rst,
  input  logic spi_sclk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_n_s,
  output logic mosi_s
);

  // [0],[1] are the synchroniser stages; [2] is the previous
  // synchronised value used for edge detection.
  logic [2:0] sclk_q, sclk_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;

  always_comb begin
    sclk_d = {sclk_q[1:0], spi_sclk};
    cs_d   = {cs_q[1:0], spi_cs_n};
    mosi_d = {mosi_q[0], spi_mosi};
  end

  // cs_n chain resets to the deselected level so leaving reset never
  // looks like the end of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= sclk_d;
      cs_q   <= cs_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_n_s    = cs_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/aes_spi_slave.sv
// SPI slave front-end for the AES core (SPI mode 0, oversampled by clk).
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : aes_spi_slave_if.slave -- SPI pins, AES core handshake
//              (start/encrypt/data/key/done/result) and status flags
//              (busy, result_valid, frame_err)
// Write frame: cmd(8) | data(128) | key(KEY_W), MSB first.
// Read frame : cmd(8) | 128 result bits shifted out on MISO.
module aes_spi_slave
  import aes_spi_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic           clk,
  input  logic           rst,
  aes_spi_slave_if.slave bus
);

  localparam int KEY_W = Nk * 32;
  localparam int SH_W  = BLK_W + KEY_W;
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(wr_bits(KEY_W));
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_BITS);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

  spi_pin_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (bus.spi_sclk),
    .spi_cs_n  (bus.spi_cs_n),
    .spi_mosi  (bus.spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         cmd_q, cmd_d, cmd_next;
  logic [SH_W-1:0]    shift_q, shift_d;
  logic [BLK_W-1:0]   miso_sh_q, miso_sh_d;
  logic [BLK_W-1:0]   result_q, result_d;
  logic [BLK_W-1:0]   data_q, data_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               rd_ok_q, rd_ok_d;
  logic               miso_q, miso_d;
  logic               enc_q, enc_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    shift_d   = shift_q;
    miso_sh_d = miso_sh_q;
    result_d  = result_q;
    data_d    = data_q;
    key_d     = key_q;
    rd_ok_d   = rd_ok_q;
    miso_d    = miso_q;
    enc_d     = enc_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    cmd_next  = {cmd_q[6:0], mosi_s};

    // Core handshake. Frame acceptance below only acts in IDLE/READY,
    // so a done in BUSY never competes with it for the same registers.
    case (state_q)
      START: state_d = BUSY;
      BUSY: begin
        if (bus.aes_done) begin
          result_d = bus.aes_result;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = READY;
        end
      end
      default: ;
    endcase

    if (cs_fall) begin
      bit_cnt_d = '0;
      cmd_d     = '0;
      rd_ok_d   = 1'b0;
      miso_d    = 1'b0;
    end else if (!cs_n_s && sclk_rise) begin
      // Saturate so an over-long frame can never alias to a legal count.
      if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q < CNT_W'(8)) begin
        cmd_d = cmd_next;
        // Last command bit: arm the read-back shifter if a result exists.
        if (bit_cnt_q == CNT_W'(7) && cmd_next == CMD_RD && valid_q) begin
          rd_ok_d   = 1'b1;
          miso_sh_d = result_q;
        end
      end else begin
        shift_d = {shift_q[SH_W-2:0], mosi_s};
      end
    end else if (!cs_n_s && sclk_fall && rd_ok_q) begin
      miso_d    = miso_sh_q[BLK_W-1];
      miso_sh_d = {miso_sh_q[BLK_W-2:0], 1'b0};
    end

    if (cs_rise) begin
      rd_ok_d = 1'b0;
      miso_d  = 1'b0;
      if (bit_cnt_q >= CNT_W'(8) && (cmd_q == CMD_ENC || cmd_q == CMD_DEC)) begin
        if (bit_cnt_q == WR_CNT && (state_q == IDLE || state_q == READY)) begin
          data_d  = shift_q[SH_W-1 -: BLK_W];
          key_d   = shift_q[KEY_W-1:0];
          enc_d   = (cmd_q == CMD_ENC);
          start_d = 1'b1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = START;
        end else begin
          err_d = 1'b1;
        end
      end else if (bit_cnt_q >= CNT_W'(8) && cmd_q == CMD_RD) begin
        if (state_q != READY) begin
          err_d = 1'b1;
        end else if (bit_cnt_q == RD_CNT) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        // A partial read leaves the result in place for a retry.
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      shift_q   <= '0;
      miso_sh_q <= '0;
      result_q  <= '0;
      data_q    <= '0;
      key_q     <= '0;
      rd_ok_q   <= 1'b0;
      miso_q    <= 1'b0;
      enc_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      shift_q   <= shift_d;
      miso_sh_q <= miso_sh_d;
      result_q  <= result_d;
      data_q    <= data_d;
      key_q     <= key_d;
      rd_ok_q   <= rd_ok_d;
      miso_q    <= miso_d;
      enc_q     <= enc_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // MISO is forced low whenever the slave is deselected.
  assign bus.spi_miso     = miso_q & ~cs_n_s;
  assign bus.aes_start    = start_q;
  assign bus.aes_encrypt  = enc_q;
  assign bus.aes_data     = data_q;
  assign bus.aes_key      = key_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_aes_spi_slave.sv
// Self-checking bench for aes_spi_slave: a bit-banged SPI master, a
// behavioural AES core stand-in, and scenario tasks with inline checks.
module tb_aes_spi_slave;
  import aes_spi_pkg::*;

  localparam int KEY_W = 128;
  localparam int HALF  = 6;   // sclk half period in clk cycles
  localparam int WR_N  = 8 + 128 + KEY_W;
  localparam int RD_N  = 136;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes_spi_slave_if #(.KEY_W(KEY_W)) bus ();

  aes_spi_slave #(.Nk(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_total = 0;
  int err_total = 0;
  int core_delay = 20;
  int core_cnt;

  // Known-answer AES vectors; anything else gets a deterministic mix.
  function automatic logic [127:0] core_model(input logic enc, input logic [127:0] d,
                                              input logic [127:0] k);
    if (enc && d == PT && k == KEY) return CT;
    if (!enc && d == CT && k == KEY) return PT;
    if (enc) return d ^ k ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_f0f0_1234_5678;
    return {d[63:0], d[127:64]} ^ k;
  endfunction

  always @(posedge clk) begin
    start_total <= start_total + int'(bus.aes_start);
    err_total   <= err_total + int'(bus.frame_err);
  end

  // Core stand-in: done pulse core_delay cycles after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt       <= 0;
      bus.aes_done   <= 1'b0;
      bus.aes_result <= '0;
    end else begin
      bus.aes_done <= 1'b0;
      if (bus.aes_start) begin
        core_cnt <= core_delay;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          bus.aes_done   <= 1'b1;
          bus.aes_result <= core_model(bus.aes_encrypt, bus.aes_data, bus.aes_key);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic bit [399:0] wr_frame(input logic [7:0] cmd, input logic [127:0] d,
                                          input logic [127:0] k);
    return {136'b0, cmd, d, k};
  endfunction

  function automatic bit [399:0] rd_frame();
    return {264'b0, CMD_RD, 128'b0};
  endfunction

  // Mode-0 master: MOSI set while sclk low, MISO sampled just before rise.
  task automatic spi_xfer(input int nbits, input bit [399:0] tx, output bit [399:0] rx);
    rx = '0;
    @(negedge clk);
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = tx[nbits-1-i];
      repeat (HALF) @(negedge clk);
      rx[nbits-1-i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
    $display("spi frame: %0d bits, tx_cmd=%02h", nbits, tx[nbits-1 -: 8]);
  endtask

  task automatic wait_not_busy(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.aes_start, bus.aes_encrypt, bus.busy, bus.result_valid, bus.frame_err,
         bus.spi_miso} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000", {bus.aes_start, bus.aes_encrypt,
               bus.busy, bus.result_valid, bus.frame_err, bus.spi_miso});
    end
    n_cmp++;
    if (bus.aes_data !== 128'h0 || bus.aes_key !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_data_key: got %h/%h want 0/0", bus.aes_data, bus.aes_key);
    end
    $display("reset: done");
  endtask

  task automatic test_read_empty();
    bit [399:0] rx;
    int e0 = err_total;
    spi_xfer(RD_N, rd_frame(), rx);
    n_cmp++;
    if (rx[135:0] !== 136'h0) begin
      n_bad++;
      $display("FAIL read_empty_miso: got %h want 0", rx[135:0]);
    end
    n_cmp++;
    if (err_total - e0 !== 1) begin
      n_bad++;
      $display("FAIL read_empty_err: got %0d pulses want 1", err_total - e0);
    end
  endtask

  task automatic test_bad_frames();
    bit [399:0] rx;
    int e0 = err_total;
    int s0 = start_total;
    // 100-bit truncated write: top 100 bits of a full write frame.
    spi_xfer(100, wr_frame(CMD_ENC, PT, KEY) >> (WR_N - 100), rx);
    n_cmp++;
    if (err_total - e0 !== 1 || start_total - s0 !== 0) begin
      n_bad++;
      $display("FAIL short_write: got err=%0d start=%0d want err=1 start=0",
               err_total - e0, start_total - s0);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.aes_data !== 128'h0) begin
      n_bad++;
      $display("FAIL short_write_state: got busy=%b valid=%b data=%h want 0/0/0",
               bus.busy, bus.result_valid, bus.aes_data);
    end
    e0 = err_total;
    spi_xfer(16, {384'b0, 8'h5a, 8'hff}, rx);
    n_cmp++;
    if (err_total - e0 !== 1 || start_total - s0 !== 0) begin
      n_bad++;
      $display("FAIL bad_cmd: got err=%0d start=%0d want err=1 start=0",
               err_total - e0, start_total - s0);
    end
  endtask

  task automatic test_write_read(input logic enc, input logic [127:0] d, input logic [127:0] k);
    bit [399:0] rx;
    bit ok;
    int s0 = start_total;
    int e0 = err_total;
    logic [127:0] exp_res = core_model(enc, d, k);
    spi_xfer(WR_N, wr_frame(enc ? CMD_ENC : CMD_DEC, d, k), rx);
    n_cmp++;
    if (start_total - s0 !== 1 || err_total - e0 !== 0) begin
      n_bad++;
      $display("FAIL write_start: got start=%0d err=%0d want start=1 err=0",
               start_total - s0, err_total - e0);
    end
    n_cmp++;
    if (bus.aes_encrypt !== enc || bus.aes_data !== d || bus.aes_key !== k) begin
      n_bad++;
      $display("FAIL write_latch: got enc=%b data=%h key=%h want enc=%b data=%h key=%h",
               bus.aes_encrypt, bus.aes_data, bus.aes_key, enc, d, k);
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL write_busy: got busy=%b valid=%b want 1/0", bus.busy, bus.result_valid);
    end
    wait_not_busy(200, ok);
    n_cmp++;
    if (!ok || bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL done_valid: got ok=%b valid=%b want 1/1", ok, bus.result_valid);
    end
    spi_xfer(RD_N, rd_frame(), rx);
    n_cmp++;
    if (rx[127:0] !== exp_res) begin
      n_bad++;
      $display("FAIL read_result: got %h want %h", rx[127:0], exp_res);
    end
    n_cmp++;
    if (bus.result_valid !== 1'b0 || err_total - e0 !== 0) begin
      n_bad++;
      $display("FAIL read_clear: got valid=%b err=%0d want 0/0", bus.result_valid, err_total - e0);
    end
  endtask

  task automatic test_busy_write_and_partial_read();
    bit [399:0] rx;
    bit ok;
    int s0 = start_total;
    int e0;
    logic [127:0] exp_res = core_model(1'b1, PT, KEY);
    core_delay = 5000;
    spi_xfer(WR_N, wr_frame(CMD_ENC, PT, KEY), rx);
    e0 = err_total;
    spi_xfer(WR_N, wr_frame(CMD_DEC, CT, ~KEY), rx);
    n_cmp++;
    if (err_total - e0 !== 1 || start_total - s0 !== 1) begin
      n_bad++;
      $display("FAIL busy_write: got err=%0d start=%0d want err=1 start=1",
               err_total - e0, start_total - s0);
    end
    n_cmp++;
    if (bus.aes_data !== PT || bus.aes_key !== KEY || bus.aes_encrypt !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_write_hold: got data=%h key=%h want data=%h key=%h",
               bus.aes_data, bus.aes_key, PT, KEY);
    end
    wait_not_busy(6000, ok);
    core_delay = 20;
    n_cmp++;
    if (!ok || bus.result_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_done: got ok=%b valid=%b want 1/1", ok, bus.result_valid);
    end
    e0 = err_total;
    spi_xfer(40, rd_frame() >> 96, rx);
    n_cmp++;
    if (rx[31:0] !== exp_res[127:96] || bus.result_valid !== 1'b1 || err_total - e0 !== 0) begin
      n_bad++;
      $display("FAIL partial_read: got bits=%h valid=%b err=%0d want bits=%h valid=1 err=0",
               rx[31:0], bus.result_valid, err_total - e0, exp_res[127:96]);
    end
    spi_xfer(RD_N, rd_frame(), rx);
    n_cmp++;
    if (rx[127:0] !== exp_res || bus.result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reread_full: got %h valid=%b want %h valid=0",
               rx[127:0], bus.result_valid, exp_res);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      logic enc = 1'($urandom_range(0, 1));
      logic [127:0] d = {$urandom(), $urandom(), $urandom(), $urandom()};
      logic [127:0] k = {$urandom(), $urandom(), $urandom(), $urandom()};
      test_write_read(enc, d, k);
    end
  endtask

  task automatic test_reset_busy();
    bit [399:0] rx;
    core_delay = 5000;
    spi_xfer(WR_N, wr_frame(CMD_ENC, PT, KEY), rx);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre_busy: got busy=%b want 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.spi_miso !== 1'b0 ||
        bus.aes_data !== 128'h0) begin
      n_bad++;
      $display("FAIL rst_busy: got busy=%b valid=%b miso=%b data=%h want 0/0/0/0",
               bus.busy, bus.result_valid, bus.spi_miso, bus.aes_data);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    core_delay = 20;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_after: got valid=%b busy=%b want 0/0", bus.result_valid, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_read_empty();
    test_bad_frames();
    test_write_read(1'b1, PT, KEY);
    test_write_read(1'b0, CT, KEY);
    test_busy_write_and_partial_read();
    test_random();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
